// File: rtl/data_packer.sv
// -----------------------------------------------------------------------------
// data_packer
//   Reads DATA_W-bit words from an upstream FIFO and packs WORDS of them into
//   one DATA_W*WORDS-bit output word. The first word of a group lands in the
//   least-significant slice and the last word in the most-significant slice.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst          : synchronous, active-high reset
//   empty        : upstream FIFO empty flag (1 = no word available)
//   data_in      : upstream FIFO read data, valid one cycle after enable
//   enable       : upstream FIFO read strobe, one word consumed per high cycle
//   valid        : one-cycle pulse when a new packed word appears on data_out
//   data_out     : most recent completed packed word (held between updates)
//   o_dbg_state  : FSM state for observation (0 = REQ, 1 = CAP)
//
// Handshake
//   enable is asserted combinationally in REQ whenever empty is low and rst is
//   low. The FIFO presents the word during the following cycle (CAP), and it
//   is captured on the edge that ends CAP. enable is always low in CAP, so at
//   most one read is ever outstanding and each word takes at least 2 cycles.
// -----------------------------------------------------------------------------
module data_packer #(
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      empty,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      enable,
  output logic                      valid,
  output logic [DATA_W*WORDS-1:0]   data_out,
  output logic                      o_dbg_state
);

  localparam int TOT_W = DATA_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  typedef enum logic {
    REQ = 1'b0,
    CAP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TOT_W-1:0]   r_shift;
  logic [TOT_W-1:0]   r_dout;
  logic               r_valid;

  logic [TOT_W-1:0]   w_shift_next;
  logic               w_capture;
  logic               w_last;

  // FSM next state and read strobe. rst gates enable so no word is consumed
  // from the FIFO while the packer is being cleared.
  always_comb begin
    w_next_state = r_state;
    enable       = 1'b0;
    case (r_state)
      REQ: begin
        enable = !empty && !rst;
        if (!empty) w_next_state = CAP;
      end
      CAP: begin
        w_next_state = REQ;
      end
      default: w_next_state = REQ;
    endcase
  end

  // Shift toward the LSB with the new word entering the top slice, so after
  // WORDS captures the oldest word sits in bits [DATA_W-1:0].
  always_comb begin
    w_shift_next = r_shift;
    for (int i = 0; i < WORDS - 1; i++) begin
      w_shift_next[i*DATA_W +: DATA_W] = r_shift[(i+1)*DATA_W +: DATA_W];
    end
    w_shift_next[TOT_W-1 -: DATA_W] = data_in;
  end

  assign w_capture = (r_state == CAP);
  assign w_last    = w_capture && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_cnt   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= w_last;
      if (w_capture) begin
        r_shift <= w_shift_next;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      // The completing word is taken from the shift-next value so it is
      // included in the published pack on the same edge.
      if (w_last) begin
        r_dout <= w_shift_next;
      end
    end
  end

  assign valid       = r_valid;
  assign data_out    = r_dout;
  assign o_dbg_state = (r_state == CAP);

endmodule

// File: tb/tb_data_packer.sv
module tb_data_packer;

  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int TOT_W  = DATA_W * WORDS;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              rst;
  logic              empty;
  logic [DATA_W-1:0] data_in;
  logic              enable;
  logic              valid;
  logic [TOT_W-1:0]  data_out;
  logic              dbg_state;

  always #5 clk = ~clk;

  data_packer #(.DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .empty       (empty),
    .data_in     (data_in),
    .enable      (enable),
    .valid       (valid),
    .data_out    (data_out),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [TOT_W-1:0] obs,
                       input logic [TOT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- FIFO model
  logic [DATA_W-1:0] src_q[$];
  logic              stall = 1'b0;
  logic              took;

  initial begin
    data_in = '0;
    empty   = 1'b1;
    forever begin
      @(posedge clk);
      took = enable;
      #2;
      if (took) begin
        if (src_q.size() > 0) data_in = src_q.pop_front();
        else check("fifo_underflow", 1, 0);
      end
      empty = (src_q.size() == 0) || stall;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [TOT_W-1:0] exp_q[$];
  logic [TOT_W-1:0] exp_hold = '0;
  int               n_valid = 0;
  int               cyc = 0;
  int               vt_q[$];
  logic             samp_rst = 1'b0;
  logic             prev_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    samp_rst = rst;
  end

  always @(negedge clk) begin
    if (samp_rst) exp_hold = '0;
    check("en_proto", enable && (prev_en || empty || rst), 0);
    prev_en = enable;
    if (valid) begin
      n_valid++;
      vt_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_hold = exp_q.pop_front();
        check("dout_on_valid", data_out, exp_hold);
      end
    end else begin
      check("dout_hold", data_out, exp_hold);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic push_words(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(base + DATA_W'(i));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, exp_q.size() == 0, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_src_empty(input int budget);
    for (int i = 0; i < budget && src_q.size() != 0; i++) @(posedge clk);
    check("src_drain", src_q.size() == 0, 1);
  endtask

  int v0;

  initial begin
    rst = 1'b1;

    // Reset held with words available: nothing may be read or published.
    push_words(16'h5555, 8);
    repeat (10) begin
      @(negedge clk);
      #1;
      check("rst_enable", enable, 0);
      check("rst_valid", valid, 0);
      check("rst_dout", data_out, 0);
    end
    src_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic pack of words 0..7.
    v0 = n_valid;
    exp_q.push_back(128'h0007_0006_0005_0004_0003_0002_0001_0000);
    push_words(16'h0000, 8);
    wait_drain("basic_drain", 100);
    check("basic_pulses", n_valid - v0, 1);

    // Long empty stall in the middle of a group.
    v0 = n_valid;
    exp_q.push_back(128'h0027_0026_0025_0024_0023_0022_0021_0020);
    push_words(16'h0020, 4);
    wait_src_empty(50);
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (20) @(posedge clk);
    check("stall_no_valid", n_valid - v0, 0);
    push_words(16'h0024, 4);
    #1 stall = 1'b0;
    wait_drain("stall_drain", 100);
    check("stall_pulses", n_valid - v0, 1);

    // Reset after three captures discards the partial group.
    push_words(16'h0010, 3);
    wait_src_empty(50);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    v0 = n_valid;
    exp_q.push_back(128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);
    push_words(16'h00A0, 8);
    wait_drain("midrst_drain", 100);
    check("midrst_pulses", n_valid - v0, 1);

    // Reset while a word is pending in CAP discards that word.
    push_words(16'h00EE, 1);
    for (int i = 0; i < 20 && !dbg_state; i++) @(negedge clk);
    check("cap_reached", dbg_state, 1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("cap_rst_state", dbg_state, 0);
    v0 = n_valid;
    exp_q.push_back(128'h00B7_00B6_00B5_00B4_00B3_00B2_00B1_00B0);
    push_words(16'h00B0, 8);
    wait_drain("caprst_drain", 100);
    check("caprst_pulses", n_valid - v0, 1);

    // Two back-to-back groups: pulses 16 cycles apart, no idle between.
    v0 = n_valid;
    exp_q.push_back(128'h0007_0006_0005_0004_0003_0002_0001_0000);
    exp_q.push_back(128'h000F_000E_000D_000C_000B_000A_0009_0008);
    push_words(16'h0000, 16);
    wait_drain("b2b_drain", 200);
    check("b2b_pulses", n_valid - v0, 2);
    if (vt_q.size() >= 2)
      check("b2b_spacing", vt_q[vt_q.size()-1] - vt_q[vt_q.size()-2], 16);
    else
      check("b2b_spacing_missing", vt_q.size(), 2);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_packer.md
DATA_PACKER -- requirements
Module: data_packer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the input word width in bits.
REQ-002 Parameter WORDS, default 8, SHALL set the number of input words per packed output word.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005 Port empty, input, 1 bit, SHALL be the upstream FIFO empty flag; high means no word is available.
REQ-006 Port data_in, input, DATA_W bits, SHALL be the upstream FIFO read data, valid one cycle after enable.
REQ-007 Port enable, output, 1 bit, SHALL be the upstream FIFO read strobe; one word is consumed per high cycle.
REQ-008 Port valid, output, 1 bit, SHALL pulse high for one cycle when a new packed word appears on data_out.
REQ-009 Port data_out, output, DATA_W*WORDS bits, SHALL carry the most recent completed packed word.

Function
REQ-010 FSM SHALL have two states, REQ (request a word) and CAP (capture the requested word).
REQ-011 In REQ, enable SHALL equal !empty (combinational); FSM SHALL move to CAP only on a cycle where enable is high, else stay in REQ.
REQ-012 In CAP, enable SHALL be 0; on that edge data_in SHALL be captured and FSM SHALL return to REQ unconditionally (empty ignored in CAP).
REQ-013 Each accepted word SHALL therefore take at least 2 cycles; no more than one read SHALL be outstanding.
REQ-014 Capture SHALL shift a WORDS-entry shift register toward the LSB, new word entering at the top slice [DATA_W*WORDS-1 -: DATA_W].
REQ-015 After WORDS captures, the first captured word SHALL occupy bits [DATA_W-1:0] and the last the top slice.
REQ-016 A word counter 0..WORDS-1 SHALL increment per capture and wrap to 0 on the WORDS-th capture.
REQ-017 On the WORDS-th capture edge, the full packed value, including that word, SHALL be loaded into the data_out register, and valid SHALL be registered high.
REQ-018 valid SHALL be high exactly the one cycle after the completing capture edge, then return to 0.
REQ-019 data_out SHALL hold its value unchanged until the next completing capture; partial packs SHALL never appear on data_out.
REQ-020 Packing of the next group SHALL start immediately in the next REQ cycle, with no idle cycle.
REQ-021 Long empty stalls SHALL not lose or duplicate words; the counter and shift register hold while stalled.

Reset
REQ-022 While rst is high: state = REQ, counter = 0, shift register = 0, data_out = 0, valid = 0, enable = 0 (rst SHALL gate enable).
REQ-023 Reset mid-pack SHALL discard captured words; the next WORDS words after reset form the next output.
REQ-024 Reset asserted in CAP SHALL discard the pending word.

Verification
REQ-025 Hold rst high for 10 cycles with empty low -> enable = 0, valid = 0, data_out = 0 throughout.
REQ-026 Release reset; feed words 0..7, each word on data_in one cycle after its enable -> exactly one valid pulse; data_out = 0x0007_0006_0005_0004_0003_0002_0001_0000; value held afterwards.
REQ-027 Hold empty high for 20 cycles mid-pack -> enable stays 0, no capture, no valid; resume with remaining words -> same packed result as without the stall.
REQ-028 Capture 3 words, assert rst for one cycle, then feed 0xA0..0xA7 -> single valid pulse with data_out = 0x00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0.
REQ-029 Feed 16 consecutive words 0..15 with empty low -> two valid pulses 16 cycles apart; data_out = {7..0} after the first pulse, held until the second, then {15..8}.
REQ-030 Check enable never high on two consecutive cycles and never high while empty is high or rst is high.
